// File: rtl/rsensor_pkg.sv
// Shared constants for the ultrasonic range-sensor trigger/echo controller.
// This package also holds the state encodings and the counter-width helper.
package rsensor_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_TRIG      = 3'd1;
   localparam logic [2:0] ST_WAIT_RISE = 3'd2;
   localparam logic [2:0] ST_MEASURE   = 3'd3;
   localparam logic [2:0] ST_HOLDOFF   = 3'd4;

   localparam int TRIG_CYCLES_DEF  = 10;
   localparam int RISE_TIMEOUT_DEF = 1000;
   localparam int HOLDOFF_DEF      = 5000;
   localparam int W_DEF            = 16;

   // The shared counter must hold the echo width and every timing terminal count.
   function automatic int cnt_width(input int w, input int trig, input int rise,
                                    input int hold);
      int r;
      r = w;
      if ($clog2(trig + 1) > r) r = $clog2(trig + 1);
      if ($clog2(rise + 1) > r) r = $clog2(rise + 1);
      if ($clog2(hold + 1) > r) r = $clog2(hold + 1);
      return r;
   endfunction

endpackage

// File: rtl/rsensor_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The flops clear asynchronously while reset is low.
module sync_2ff (
   input  logic in_clk,
   input  logic in_rst_n,
   input  logic in_d,
   output logic out_q
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= in_d;
         r_s2 <= r_s1;
      end
   end

   assign out_q = r_s2;

endmodule

// File: rtl/rsensor_ctrl.sv
// Initiator for an ultrasonic range sensor: fires a trigger pulse, times the echo,
// and enforces a hold-off before the next shot. out_state exposes the FSM state.
module rsensor_ctrl
   import rsensor_pkg::*;
#(
   parameter int TRIG_CYCLES  = TRIG_CYCLES_DEF,
   parameter int RISE_TIMEOUT = RISE_TIMEOUT_DEF,
   parameter int HOLDOFF      = HOLDOFF_DEF,
   parameter int W            = W_DEF
) (
   input  logic         in_clk,
   input  logic         in_rst_n,
   input  logic         in_start,
   input  logic         in_auto,
   input  logic         in_echo,
   output logic         out_trig,
   output logic         out_busy,
   output logic         out_valid,
   output logic [W-1:0] out_width,
   output logic         out_timeout,
   output logic [2:0]   out_state
);

   localparam int CW = cnt_width(W, TRIG_CYCLES, RISE_TIMEOUT, HOLDOFF);

   localparam logic [CW-1:0] C_ONE       = CW'(1);
   localparam logic [CW-1:0] C_TRIG_LAST = CW'(TRIG_CYCLES - 1);
   localparam logic [CW-1:0] C_RISE_LAST = CW'(RISE_TIMEOUT - 1);
   localparam logic [CW-1:0] C_HOLD_LAST = CW'(HOLDOFF - 1);
   localparam logic [CW-1:0] C_MAX       = CW'({W{1'b1}});

   logic [2:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_trig;
   logic          r_valid;
   logic [W-1:0]  r_width;
   logic          r_timeout;
   logic          w_echo_s;

   sync_2ff u_sync_echo (
      .in_clk   (in_clk),
      .in_rst_n (in_rst_n),
      .in_d     (in_echo),
      .out_q    (w_echo_s)
   );

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_trig    <= 1'b0;
         r_valid   <= 1'b0;
         r_width   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (in_start || in_auto) begin
                  r_state <= ST_TRIG;
                  r_cnt   <= '0;
                  r_trig  <= 1'b1;
               end
            end
            ST_TRIG: begin
               if (r_cnt == C_TRIG_LAST) begin
                  r_state <= ST_WAIT_RISE;
                  r_cnt   <= '0;
                  r_trig  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            ST_WAIT_RISE: begin
               // The sample that sees the rise counts as the first high clock.
               if (w_echo_s) begin
                  r_state <= ST_MEASURE;
                  r_cnt   <= C_ONE;
               end else if (r_cnt == C_RISE_LAST) begin
                  r_state   <= ST_HOLDOFF;
                  r_cnt     <= '0;
                  r_valid   <= 1'b1;
                  r_timeout <= 1'b1;
                  r_width   <= '0;
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            ST_MEASURE: begin
               if (!w_echo_s) begin
                  r_state   <= ST_HOLDOFF;
                  r_cnt     <= '0;
                  r_valid   <= 1'b1;
                  r_timeout <= 1'b0;
                  r_width   <= r_cnt[W-1:0];
               end else if (r_cnt == C_MAX) begin
                  r_state   <= ST_HOLDOFF;
                  r_cnt     <= '0;
                  r_valid   <= 1'b1;
                  r_timeout <= 1'b1;
                  r_width   <= {W{1'b1}};
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            ST_HOLDOFF: begin
               // Count stops at the terminal value so a stuck echo cannot wrap it.
               if ((r_cnt >= C_HOLD_LAST) && !w_echo_s) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt < C_HOLD_LAST) begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_trig  <= 1'b0;
            end
         endcase
      end
   end

   assign out_trig    = r_trig;
   assign out_busy    = (r_state != ST_IDLE);
   assign out_valid   = r_valid;
   assign out_width   = r_width;
   assign out_timeout = r_timeout;
   assign out_state   = r_state;

endmodule

// File: tb/tb_rsensor_ctrl.sv
// Directed bench for rsensor_ctrl with small timing parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_rsensor_ctrl;
   import rsensor_pkg::*;

   localparam int TRIG_C = 10;
   localparam int RISE_T = 50;
   localparam int HOLD_C = 20;
   localparam int WW     = 8;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          auto_m;
   logic          echo;
   logic          trig;
   logic          busy;
   logic          valid;
   logic [WW-1:0] width;
   logic          tmo;
   logic [2:0]    state;

   int n_cmp;
   int n_err;

   rsensor_ctrl #(
      .TRIG_CYCLES  (TRIG_C),
      .RISE_TIMEOUT (RISE_T),
      .HOLDOFF      (HOLD_C),
      .W            (WW)
   ) dut (
      .in_clk      (clk),
      .in_rst_n    (rst_n),
      .in_start    (start),
      .in_auto     (auto_m),
      .in_echo     (echo),
      .out_trig    (trig),
      .out_busy    (busy),
      .out_valid   (valid),
      .out_width   (width),
      .out_timeout (tmo),
      .out_state   (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // sel: 0 = trig, 1 = valid, 2 = busy. n = falling edges waited, -1 on timeout.
   task automatic wait_for(input int sel, input logic lvl, input int max_cyc, output int n);
      logic v;
      n = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         n++;
         case (sel)
            0:       v = trig;
            1:       v = valid;
            default: v = busy;
         endcase
         if (v == lvl) return;
      end
      n = -1;
   endtask

   task automatic echo_pulse(input int len);
      echo = 1'b1;
      repeat (len) tick();
      echo = 1'b0;
   endtask

   initial begin
      int n;
      int vcnt;
      int tcnt;
      logic [WW-1:0] w_seen;
      logic          t_seen;

      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0;
      auto_m = 1'b0;
      echo = 1'b0;
      repeat (3) tick();
      check("rst_trig", {31'd0, trig}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_width", {24'd0, width}, 32'd0);
      check("rst_state", {29'd0, state}, {29'd0, ST_IDLE});
      rst_n = 1'b1;
      tick();

      // 1: trigger pulse width and busy
      start = 1'b1;
      wait_for(0, 1'b1, 5, n);
      check("t1_trig_rise", n, 32'd1);
      check("t1_busy", {31'd0, busy}, 32'd1);
      start = 1'b0;
      wait_for(0, 1'b0, 30, n);
      check("t1_trig_len", n, TRIG_C);

      // 2: 100-clock echo, then hold-off spacing to the next trigger
      repeat (5) tick();
      echo_pulse(100);
      wait_for(1, 1'b1, 20, n);
      check("t2_valid_seen", {31'd0, (n != -1)}, 32'd1);
      check("t2_width", {24'd0, width}, 32'd100);
      check("t2_timeout", {31'd0, tmo}, 32'd0);
      start = 1'b1;
      wait_for(0, 1'b1, 60, n);
      check("t2_retrig_gap", n, HOLD_C + 1);
      start = 1'b0;

      // 3: no echo -> timeout result; start during hold-off is ignored
      wait_for(0, 1'b0, 30, n);
      check("t3_trig_len", n, TRIG_C);
      wait_for(1, 1'b1, 100, n);
      check("t3_rise_timeout", n, RISE_T);
      check("t3_timeout", {31'd0, tmo}, 32'd1);
      check("t3_width", {24'd0, width}, 32'd0);
      tick();
      check("t3_valid_1cyc", {31'd0, valid}, 32'd0);
      check("t3_state_hold", {29'd0, state}, {29'd0, ST_HOLDOFF});
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_for(2, 1'b0, 60, n);
      check("t3_idle_reached", {31'd0, (n != -1)}, 32'd1);
      check("t3_state_idle", {29'd0, state}, {29'd0, ST_IDLE});
      tcnt = 0;
      repeat (30) begin
         tick();
         if (trig || busy) tcnt++;
      end
      check("t3_start_not_queued", tcnt, 32'd0);

      // 4: stuck-high echo saturates and holds the FSM in hold-off
      start = 1'b1;
      wait_for(0, 1'b1, 5, n);
      start = 1'b0;
      wait_for(0, 1'b0, 30, n);
      echo = 1'b1;
      vcnt = 0;
      w_seen = '0;
      t_seen = 1'b0;
      repeat (300) begin
         tick();
         if (valid) begin
            vcnt++;
            w_seen = width;
            t_seen = tmo;
         end
      end
      check("t4_valid_count", vcnt, 32'd1);
      check("t4_width_sat", {24'd0, w_seen}, 32'd255);
      check("t4_timeout_sat", {31'd0, t_seen}, 32'd1);
      check("t4_stuck_holdoff", {29'd0, state}, {29'd0, ST_HOLDOFF});
      echo = 1'b0;
      wait_for(2, 1'b0, 20, n);
      check("t4_release_lag", n, 32'd3);

      // 5: auto mode, three 40-clock echoes back to back
      auto_m = 1'b1;
      wait_for(0, 1'b1, 5, n);
      check("t5_first_trig", n, 32'd1);
      for (int k = 0; k < 3; k++) begin
         wait_for(0, 1'b0, 30, n);
         check("t5_trig_len", n, TRIG_C);
         start = 1'b1;
         tick();
         start = 1'b0;
         repeat (2) tick();
         if (k == 2) auto_m = 1'b0;
         echo_pulse(40);
         wait_for(1, 1'b1, 20, n);
         check("t5_valid_seen", {31'd0, (n != -1)}, 32'd1);
         check("t5_width", {24'd0, width}, 32'd40);
         check("t5_timeout", {31'd0, tmo}, 32'd0);
         if (k < 2) begin
            wait_for(0, 1'b1, 60, n);
            check("t5_auto_gap", n, HOLD_C + 1);
         end
      end
      wait_for(2, 1'b0, 60, n);
      check("t5_idle_reached", {31'd0, (n != -1)}, 32'd1);
      tcnt = 0;
      repeat (30) begin
         tick();
         if (trig) tcnt++;
      end
      check("t5_auto_off", tcnt, 32'd0);

      // 6: reset mid-trigger and mid-measure
      start = 1'b1;
      wait_for(0, 1'b1, 5, n);
      start = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check("t6_trig_drop", {31'd0, trig}, 32'd0);
      check("t6_busy_drop_trig", {31'd0, busy}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      start = 1'b1;
      wait_for(0, 1'b1, 5, n);
      start = 1'b0;
      wait_for(0, 1'b0, 30, n);
      echo = 1'b1;
      repeat (10) tick();
      check("t6_in_measure", {29'd0, state}, {29'd0, ST_MEASURE});
      rst_n = 1'b0;
      #1;
      check("t6_busy_drop", {31'd0, busy}, 32'd0);
      check("t6_valid_drop", {31'd0, valid}, 32'd0);
      check("t6_trig_low", {31'd0, trig}, 32'd0);
      check("t6_width_clr", {24'd0, width}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      echo = 1'b0;
      vcnt = 0;
      tcnt = 0;
      repeat (40) begin
         tick();
         if (valid) vcnt++;
         if (trig) tcnt++;
      end
      check("t6_no_valid_after", vcnt, 32'd0);
      check("t6_no_trig_after", tcnt, 32'd0);
      start = 1'b1;
      wait_for(0, 1'b1, 5, n);
      start = 1'b0;
      wait_for(0, 1'b0, 30, n);
      check("t6_trig_len", n, TRIG_C);
      repeat (3) tick();
      echo_pulse(25);
      wait_for(1, 1'b1, 20, n);
      check("t6_valid_seen", {31'd0, (n != -1)}, 32'd1);
      check("t6_width", {24'd0, width}, 32'd25);
      check("t6_timeout", {31'd0, tmo}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
